// File: rtl/seven_seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seven_seg_pkg                                                    |
// | Brief   : Segment type and hex glyph table shared by encode/decode sides.  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    // Active-low, bit0 = a .. bit6 = g
    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t SEG_CODE [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage
`default_nettype wire

// File: rtl/seven_segment_pattern_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seven_segment_pattern_decoder                                    |
// | Brief   : Maps an active-low segment pattern back to a hex nibble.         |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module seven_segment_pattern_decoder
    import seven_seg_pkg::*;
(
    input  seg_t       seg,
    output logic [3:0] nibble,
    output logic       legal,
    output logic       blank
);

    always_comb begin
        nibble = 4'h0;
        legal  = 1'b0;
        blank  = 1'b0;
        if (seg == SEG_BLANK) begin
            legal = 1'b1;
            blank = 1'b1;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (seg == SEG_CODE[i]) begin
                    nibble = 4'(i);
                    legal  = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seven_segment_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seven_segment_scan_decoder                                       |
// | Brief   : Recovers hex frames from a multiplexed active-low 7-seg bus.     |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module seven_segment_scan_decoder
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   blank_mask,
    output logic                    frame_valid,
    output logic                    code_err,
    output logic [ERR_CNT_W-1:0]    err_count
);

    localparam int             CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 1);

    seg_t                    r_seg_q, r_seg_prev;
    logic [NUM_DIGITS-1:0]   r_sel_q, r_sel_prev;
    logic [CNT_W-1:0]        r_cnt;

    logic                    r_cap_vld;
    logic [NUM_DIGITS-1:0]   r_cap_sel;
    logic [3:0]              r_cap_nib;
    logic                    r_cap_blank;
    logic                    r_cap_legal;

    logic [4*NUM_DIGITS-1:0] r_shadow_nib;
    logic [NUM_DIGITS-1:0]   r_shadow_blank;
    logic [NUM_DIGITS-1:0]   r_seen;
    logic [4*NUM_DIGITS-1:0] r_value;
    logic [NUM_DIGITS-1:0]   r_blank_mask;
    logic                    r_frame_valid;
    logic                    r_code_err;
    logic [ERR_CNT_W-1:0]    r_err_count;

    logic                    w_stable;
    logic                    w_capture;
    logic [3:0]              w_dec_nib;
    logic                    w_dec_legal;
    logic                    w_dec_blank;
    logic [NUM_DIGITS-1:0]   w_cap_bit;
    logic [4*NUM_DIGITS-1:0] w_nib_merged;
    logic [NUM_DIGITS-1:0]   w_blank_merged;
    logic                    w_commit;

    seven_segment_pattern_decoder u_pattern_decoder (
        .seg    (r_seg_q),
        .nibble (w_dec_nib),
        .legal  (w_dec_legal),
        .blank  (w_dec_blank)
    );

    // A select that is zero or multi-hot never counts as stable (ghosting/blanking)
    assign w_stable  = (r_seg_q == r_seg_prev) && (r_sel_q == r_sel_prev) && $onehot(r_sel_q);
    assign w_capture = w_stable && (r_cnt == CNT_CAP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_q     <= '0;
            r_seg_prev  <= '0;
            r_sel_q     <= '0;
            r_sel_prev  <= '0;
            r_cnt       <= '0;
            r_cap_vld   <= 1'b0;
            r_cap_sel   <= '0;
            r_cap_nib   <= '0;
            r_cap_blank <= 1'b0;
            r_cap_legal <= 1'b0;
        end else begin
            r_seg_q     <= seg_in;
            r_seg_prev  <= r_seg_q;
            r_sel_q     <= dig_sel;
            r_sel_prev  <= r_sel_q;
            if (!w_stable) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_cap_vld   <= w_capture;
            r_cap_sel   <= r_sel_q;
            r_cap_nib   <= w_dec_nib;
            r_cap_blank <= w_dec_blank;
            r_cap_legal <= w_dec_legal;
        end
    end

    assign w_cap_bit = (r_cap_vld && r_cap_legal) ? r_cap_sel : '0;

    always_comb begin
        w_nib_merged   = r_shadow_nib;
        w_blank_merged = r_shadow_blank;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_cap_bit[i]) begin
                w_nib_merged[4*i +: 4] = r_cap_nib;
                w_blank_merged[i]      = r_cap_blank;
            end
        end
    end

    // Commit includes the digit captured in this same cycle
    assign w_commit = (w_cap_bit != '0) && ((r_seen | w_cap_bit) == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow_nib   <= '0;
            r_shadow_blank <= '0;
            r_seen         <= '0;
            r_value        <= '0;
            r_blank_mask   <= '1;
            r_frame_valid  <= 1'b0;
            r_code_err     <= 1'b0;
            r_err_count    <= '0;
        end else begin
            r_frame_valid  <= 1'b0;
            r_code_err     <= 1'b0;
            r_shadow_nib   <= w_nib_merged;
            r_shadow_blank <= w_blank_merged;
            if (r_cap_vld && !r_cap_legal) begin
                r_code_err <= 1'b1;
                if (r_err_count != '1) begin
                    r_err_count <= r_err_count + ERR_CNT_W'(1);
                end
            end
            if (w_commit) begin
                r_value       <= w_nib_merged;
                r_blank_mask  <= w_blank_merged;
                r_frame_valid <= 1'b1;
                r_seen        <= '0;
            end else begin
                r_seen <= r_seen | w_cap_bit;
            end
        end
    end

    assign value       = r_value;
    assign blank_mask  = r_blank_mask;
    assign frame_valid = r_frame_valid;
    assign code_err    = r_code_err;
    assign err_count   = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_seven_segment_scan_decoder                                    |
// | Brief   : Directed + random scan bench against a run-length reference.     |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_seven_segment_scan_decoder;

    localparam int N  = 4;
    localparam int S  = 4;
    localparam int EW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    seg_in = 7'h7F;
    logic [N-1:0]  dig_sel = '0;
    logic [4*N-1:0] value;
    logic [N-1:0]  blank_mask;
    logic          frame_valid;
    logic          code_err;
    logic [EW-1:0] err_count;

    seven_segment_scan_decoder #(
        .NUM_DIGITS    (N),
        .STABLE_CYCLES (S),
        .ERR_CNT_W     (EW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .value       (value),
        .blank_mask  (blank_mask),
        .frame_valid (frame_valid),
        .code_err    (code_err),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4*N-1:0] v;
        logic [N-1:0]   b;
        logic           fv;
        logic           ce;
        logic [EW-1:0]  err;
    } snap_t;

    logic [6:0] code_tbl [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Reference: a capture happens when a one-hot (sel,seg) pair has been seen
    // on S+1 consecutive edges; its effect appears two edges later.
    snap_t          vis, d1, d2;
    logic [4*N-1:0] m_value, m_shadow;
    logic [N-1:0]   m_blank, m_shadow_blank, m_seen;
    logic [EW-1:0]  m_err;
    int             run_len;
    logic           have_last;
    logic [N-1:0]   last_sel;
    logic [6:0]     last_seg;

    int n_checks = 0;
    int n_errors = 0;
    int n_frames = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic decode(input logic [6:0] s, output logic [3:0] nib, output logic blk);
        nib = 4'h0;
        blk = 1'b0;
        if (s == 7'h7F) begin
            blk = 1'b1;
            return 1'b1;
        end
        for (int i = 0; i < 16; i++) begin
            if (code_tbl[i] == s) begin
                nib = 4'(i);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_edge(input logic r, input logic [N-1:0] sel, input logic [6:0] seg);
        snap_t      s;
        logic [3:0] nib;
        logic       blk;
        int         idx;
        if (r) begin
            m_value = '0; m_blank = '1; m_err = '0;
            m_shadow = '0; m_shadow_blank = '0; m_seen = '0;
            run_len = 0; have_last = 1'b0;
            s = '{v: '0, b: '1, fv: 1'b0, ce: 1'b0, err: '0};
            vis = s; d1 = s; d2 = s;
            return;
        end
        if (have_last && sel == last_sel && seg == last_seg) run_len++;
        else run_len = 1;
        have_last = 1'b1; last_sel = sel; last_seg = seg;
        s.fv = 1'b0;
        s.ce = 1'b0;
        if (run_len == S + 1 && $countones(sel) == 1) begin
            idx = 0;
            for (int i = 0; i < N; i++) if (sel[i]) idx = i;
            if (decode(seg, nib, blk)) begin
                m_shadow[4*idx +: 4] = nib;
                m_shadow_blank[idx]  = blk;
                m_seen[idx]          = 1'b1;
                if (m_seen == '1) begin
                    m_value = m_shadow;
                    m_blank = m_shadow_blank;
                    m_seen  = '0;
                    s.fv    = 1'b1;
                end
            end else begin
                s.ce = 1'b1;
                if (m_err != '1) m_err = m_err + 1'b1;
            end
        end
        s.v = m_value; s.b = m_blank; s.err = m_err;
        vis = d1; d1 = d2; d2 = s;
    endtask

    task automatic step(input logic r, input logic [N-1:0] sel, input logic [6:0] seg);
        rst = r; dig_sel = sel; seg_in = seg;
        @(posedge clk);
        model_edge(r, sel, seg);
        #1;
        if (frame_valid === 1'b1) n_frames++;
        check("value", 32'(value), 32'(vis.v));
        check("blank_mask", 32'(blank_mask), 32'(vis.b));
        check("frame_valid", 32'(frame_valid), 32'(vis.fv));
        check("code_err", 32'(code_err), 32'(vis.ce));
        check("err_count", 32'(err_count), 32'(vis.err));
    endtask

    task automatic hold(input logic [N-1:0] sel, input logic [6:0] seg, input int n);
        for (int i = 0; i < n; i++) step(1'b0, sel, seg);
    endtask

    task automatic flush();
        hold('0, 7'h7F, 3);
    endtask

    initial begin
        int f0;
        logic [N-1:0] rs;
        logic [6:0]   rg;
        int           pick;

        // 1: reset with the bus toggling
        for (int i = 0; i < 3; i++) step(1'b1, 4'(1 << i), 7'($urandom));
        check("t1_value", 32'(value), 32'h0);
        check("t1_blank", 32'(blank_mask), 32'hF);

        // 2: two identical scans of 0x0123
        f0 = n_frames;
        hold(4'b0001, 7'h30, 6); hold(4'b0010, 7'h24, 6);
        hold(4'b0100, 7'h79, 6); hold(4'b1000, 7'h40, 6);
        flush();
        check("t2_frames1", 32'(n_frames - f0), 32'd1);
        check("t2_value", 32'(value), 32'h0123);
        check("t2_blank", 32'(blank_mask), 32'h0);
        hold(4'b0001, 7'h30, 6); hold(4'b0010, 7'h24, 6);
        hold(4'b0100, 7'h79, 6); hold(4'b1000, 7'h40, 6);
        flush();
        check("t2_frames2", 32'(n_frames - f0), 32'd2);
        check("t2_value2", 32'(value), 32'h0123);

        // 3: window one cycle short of capture
        f0 = n_frames;
        hold(4'b0100, 7'h24, S - 1); hold(4'b0100, 7'h7F, 2);
        flush();
        check("t3_frames", 32'(n_frames - f0), 32'd0);

        // 4: illegal pattern on digit1, then repaired
        hold(4'b0010, 7'h55, 6);
        flush();
        check("t4_err", 32'(err_count), 32'd1);
        f0 = n_frames;
        hold(4'b0001, 7'h30, 6); hold(4'b0100, 7'h79, 6); hold(4'b1000, 7'h40, 6);
        flush();
        check("t4_incomplete", 32'(n_frames - f0), 32'd0);
        hold(4'b0010, 7'h08, 6);
        flush();
        check("t4_frames", 32'(n_frames - f0), 32'd1);
        check("t4_value", 32'(value), 32'h01A3);

        // 5: blanks on the upper digits
        hold(4'b1000, 7'h7F, 6); hold(4'b0100, 7'h7F, 6);
        hold(4'b0010, 7'h78, 6); hold(4'b0001, 7'h0E, 6);
        flush();
        check("t5_value", 32'(value), 32'h007F);
        check("t5_blank", 32'(blank_mask), 32'hC);

        // 6: multi-hot select, then reset mid-frame
        f0 = n_frames;
        hold(4'b0110, 7'h40, 10);
        hold(4'b0001, 7'h19, 6); hold(4'b0010, 7'h19, 6); hold(4'b0100, 7'h19, 6);
        step(1'b1, 4'b0100, 7'h19); step(1'b1, 4'b0100, 7'h19);
        hold(4'b1000, 7'h78, 6);
        flush();
        check("t6_no_frame", 32'(n_frames - f0), 32'd0);
        check("t6_reset_value", 32'(value), 32'h0);
        hold(4'b0001, 7'h02, 6); hold(4'b0010, 7'h12, 6); hold(4'b0100, 7'h19, 6);
        flush();
        check("t6_frames", 32'(n_frames - f0), 32'd1);
        check("t6_value", 32'(value), 32'h7456);

        // Randomized scanning, including illegal codes, ghosting and resets
        for (int k = 0; k < 70; k++) begin
            pick = int'($urandom_range(0, 9));
            if (pick <= 5)      rg = code_tbl[$urandom_range(0, 15)];
            else if (pick == 6) rg = 7'h7F;
            else                rg = 7'($urandom);
            if ($urandom_range(0, 7) == 0) rs = N'($urandom);
            else                           rs = N'(1 << $urandom_range(0, N - 1));
            if ($urandom_range(0, 24) == 0) step(1'b1, rs, rg);
            else hold(rs, rg, int'($urandom_range(1, 8)));
        end
        flush();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
